// File: rtl/scoreboard_forward_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard_forward_unit_if
//  Description : Signal bundle between the pipeline datapath and the
//                scoreboard/forwarding unit.
//                master : pipeline side (drives hazard inputs, receives
//                         forward selects, stall/flush controls, MC status)
//                slave  : scoreboard_forward_unit side
//  Signals     : RegWriteM/W, MemReadE, MC_issueE, PCSrcE, RegWriteD, MC_D
//                RD_E/M/W/D, Rs1_D, Rs2_D, Rs1_E, Rs2_E      (to unit)
//                ForwardAE/BE, StallF/D, FlushD/E, MC_done,
//                MC_rd, stall_cycles                          (from unit)
//  Revision    : 1.0  initial release
// ============================================================================
interface scoreboard_forward_unit_if #(
    parameter int ADDR_W      = 5,
    parameter int STALL_CNT_W = 16
);
    // Pipeline -> unit
    logic                   RegWriteM;
    logic                   RegWriteW;
    logic                   MemReadE;
    logic                   MC_issueE;
    logic                   PCSrcE;
    logic                   RegWriteD;
    logic                   MC_D;
    logic [ADDR_W-1:0]      RD_E;
    logic [ADDR_W-1:0]      RD_M;
    logic [ADDR_W-1:0]      RD_W;
    logic [ADDR_W-1:0]      RD_D;
    logic [ADDR_W-1:0]      Rs1_D;
    logic [ADDR_W-1:0]      Rs2_D;
    logic [ADDR_W-1:0]      Rs1_E;
    logic [ADDR_W-1:0]      Rs2_E;

    // Unit -> pipeline
    logic [1:0]             ForwardAE;
    logic [1:0]             ForwardBE;
    logic                   StallF;
    logic                   StallD;
    logic                   FlushD;
    logic                   FlushE;
    logic                   MC_done;
    logic [ADDR_W-1:0]      MC_rd;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output RegWriteM, RegWriteW, MemReadE, MC_issueE, PCSrcE,
               RegWriteD, MC_D,
               RD_E, RD_M, RD_W, RD_D, Rs1_D, Rs2_D, Rs1_E, Rs2_E,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               MC_done, MC_rd, stall_cycles
    );

    modport slave (
        input  RegWriteM, RegWriteW, MemReadE, MC_issueE, PCSrcE,
               RegWriteD, MC_D,
               RD_E, RD_M, RD_W, RD_D, Rs1_D, Rs2_D, Rs1_E, Rs2_E,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               MC_done, MC_rd, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/scoreboard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard_forward_unit
//  Description : Hazard unit for an in-order pipeline with one outstanding
//                fixed-latency multicycle operation. Tracks the multicycle
//                destination register (scoreboard), detects load-use and
//                scoreboard hazards, generates stall/flush controls, selects
//                forwarding sources for both E-stage operands and counts
//                stall cycles (saturating).
//  Ports       : clk           rising-edge clock
//                rst           asynchronous active-low reset
//                bus (slave)   hazard inputs / control outputs, see
//                              scoreboard_forward_unit_if
//  Parameters  : ADDR_W        register-address width (x0 = address 0)
//                MC_LAT        multicycle latency, issue to done (2..2^CNT_W)
//                CNT_W         latency down-counter width
//                STALL_CNT_W   stall-cycle counter width
//                The interface instance must use the same ADDR_W and
//                STALL_CNT_W as this module.
//  Revision    : 1.0  initial release
// ============================================================================
module scoreboard_forward_unit #(
    parameter int ADDR_W      = 5,
    parameter int MC_LAT      = 4,
    parameter int CNT_W       = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    scoreboard_forward_unit_if.slave bus
);

    // Counter reload: done is flagged when cnt reaches zero, so loading
    // MC_LAT-1 at issue puts the done cycle exactly MC_LAT cycles later.
    localparam logic [CNT_W-1:0]       CNT_LOAD  = CNT_W'(MC_LAT - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [1:0]             FWD_RF    = 2'b00;
    localparam logic [1:0]             FWD_W     = 2'b01;
    localparam logic [1:0]             FWD_M     = 2'b10;
    localparam logic [1:0]             FWD_MC    = 2'b11;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic                   mc_busy;
    logic [ADDR_W-1:0]      mc_rd_q;
    logic [CNT_W-1:0]       cnt;
    logic [STALL_CNT_W-1:0] stall_q;

    // ------------------------------------------------------------------
    // Combinational hazard detection
    // ------------------------------------------------------------------
    logic mc_done_int;      // ungated done (state already cleared in reset)
    logic mc_live;          // op in flight whose result is not yet available
    logic issue_accept;
    logic lu_hazard;
    logic sb_reg_match;
    logic sb_hazard;
    logic stall_int;

    assign mc_done_int  = mc_busy & (cnt == '0);
    assign mc_live      = mc_busy & ~mc_done_int;

    // The done cycle frees the unit, so an issue presented in that same
    // cycle is taken; the reload makes the new op wait its full latency.
    assign issue_accept = bus.MC_issueE & (~mc_busy | mc_done_int);

    assign lu_hazard    = bus.MemReadE
                        & (bus.RD_E != '0)
                        & ((bus.RD_E == bus.Rs1_D) | (bus.RD_E == bus.Rs2_D));

    // RAW on either source or WAW on the destination of the D instruction.
    // x0 never creates a dependency.
    assign sb_reg_match = (mc_rd_q != '0)
                        & ((mc_rd_q == bus.Rs1_D)
                         | (mc_rd_q == bus.Rs2_D)
                         | (bus.RegWriteD & (mc_rd_q == bus.RD_D)));

    // A second multicycle op may not enter E while one is outstanding, nor
    // collide with one being issued right now.
    assign sb_hazard    = (mc_live & (sb_reg_match | bus.MC_D))
                        | (bus.MC_issueE & bus.MC_D);

    assign stall_int    = lu_hazard | sb_hazard;

    // ------------------------------------------------------------------
    // Forward select: the multicycle result is always the youngest writer
    // (younger WAW is blocked by the scoreboard), then M, then W.
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic [ADDR_W-1:0] rs,
        input logic              mc_done,
        input logic [ADDR_W-1:0] mc_rd,
        input logic              wr_m,
        input logic [ADDR_W-1:0] rd_m,
        input logic              wr_w,
        input logic [ADDR_W-1:0] rd_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mc_done && (mc_rd != '0) && (mc_rd == rs)) begin
            sel = FWD_MC;
        end else if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    always_comb begin
        fwd_a = fwd_sel(bus.Rs1_E, mc_done_int, mc_rd_q,
                        bus.RegWriteM, bus.RD_M, bus.RegWriteW, bus.RD_W);
        fwd_b = fwd_sel(bus.Rs2_E, mc_done_int, mc_rd_q,
                        bus.RegWriteM, bus.RD_M, bus.RegWriteW, bus.RD_W);
    end

    // ------------------------------------------------------------------
    // Outputs: all combinational, forced to zero while reset is asserted
    // (the inputs may still be toggling during reset).
    // ------------------------------------------------------------------
    always_comb begin
        bus.ForwardAE    = 2'b00;
        bus.ForwardBE    = 2'b00;
        bus.StallF       = 1'b0;
        bus.StallD       = 1'b0;
        bus.FlushD       = 1'b0;
        bus.FlushE       = 1'b0;
        bus.MC_done      = 1'b0;
        bus.MC_rd        = '0;
        bus.stall_cycles = '0;
        if (rst) begin
            bus.ForwardAE    = fwd_a;
            bus.ForwardBE    = fwd_b;
            bus.StallF       = stall_int;
            bus.StallD       = stall_int;
            // Stalls remain asserted on a taken branch; the flush wins in
            // the pipeline registers.
            bus.FlushD       = bus.PCSrcE;
            bus.FlushE       = stall_int | bus.PCSrcE;
            bus.MC_done      = mc_done_int;
            bus.MC_rd        = mc_rd_q;
            bus.stall_cycles = stall_q;
        end
    end

    // ------------------------------------------------------------------
    // Multicycle tracker and stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_busy <= 1'b0;
            mc_rd_q <= '0;
            cnt     <= '0;
            stall_q <= '0;
        end else begin
            if (issue_accept) begin
                mc_busy <= 1'b1;
                mc_rd_q <= bus.RD_E;
                cnt     <= CNT_LOAD;
            end else if (mc_done_int) begin
                mc_busy <= 1'b0;
            end else if (mc_busy) begin
                cnt     <= cnt - CNT_W'(1);
            end

            if (stall_int && (stall_q != STALL_MAX)) begin
                stall_q <= stall_q + STALL_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/scoreboard_forward_unit.md
SCOREBOARD_FORWARD_UNIT -- requirements
Module: scoreboard_forward_unit

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width; x0 is address 0.
REQ-002 Parameter MC_LAT, default 4, multicycle-op latency in cycles from issue to done; legal range 2..(2^CNT_W).
REQ-003 Parameter CNT_W, default 4, width of the latency down-counter.
REQ-004 Parameter STALL_CNT_W, default 16, width of the stall-cycle performance counter.
REQ-005 One clock and one reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-low reset.
REQ-006 Inputs, all 1 bit: RegWriteM, RegWriteW, MemReadE (load in E), MC_issueE (multicycle op in E), PCSrcE (taken branch/jump in E), RegWriteD (instruction in D writes rd), MC_D (instruction in D is multicycle).
REQ-007 Inputs, all ADDR_W bits: RD_E, RD_M, RD_W, RD_D, Rs1_D, Rs2_D, Rs1_E, Rs2_E.
REQ-008 Outputs ForwardAE and ForwardBE, 2 bits each: 00 = register file, 01 = W result, 10 = M result, 11 = multicycle result.
REQ-009 Outputs StallF, StallD, FlushD, FlushE, 1 bit each.
REQ-010 Output MC_done, 1 bit: multicycle result valid this cycle. Output MC_rd, ADDR_W bits: its destination.
REQ-011 Output stall_cycles, STALL_CNT_W bits: saturating count of stall cycles.

Function
REQ-012 State: mc_busy (1 bit), mc_rd_q (ADDR_W bits), cnt (CNT_W bits), stall_cycles.
REQ-013 Issue: when MC_issueE=1 and mc_busy=0 at a rising edge, set mc_busy=1, mc_rd_q=RD_E, cnt=MC_LAT-1.
REQ-014 Count: while mc_busy=1 and cnt!=0, cnt decrements by 1 each cycle.
REQ-015 Done: MC_done=1 combinationally when mc_busy=1 and cnt==0; at that edge mc_busy clears to 0. MC_done therefore pulses for exactly one cycle, MC_LAT cycles after the issue cycle.
REQ-016 MC_rd always equals mc_rd_q.
REQ-017 A new issue while mc_busy=1 is not accepted, and state is unchanged; REQ-020 guarantees it never occurs.
REQ-018 An issue in the same cycle as MC_done is accepted, because mc_busy is sampled before clearing; MC_done must then not pulse for the new op until its own MC_LAT.
REQ-019 Load-use hazard (lu) = MemReadE & (RD_E!=0) & (RD_E==Rs1_D | RD_E==Rs2_D).
REQ-020 Scoreboard hazard (sb) = mc_busy & ~MC_done & (mc_rd_q!=0) & (mc_rd_q==Rs1_D | mc_rd_q==Rs2_D | (RegWriteD & mc_rd_q==RD_D)); sb also asserts when mc_busy & ~MC_done & MC_D.
REQ-021 Issue-collision hazard: MC_issueE & MC_D also asserts sb.
REQ-022 Stall outputs: StallF = StallD = lu | sb.
REQ-023 Flush outputs: FlushE = lu | sb | PCSrcE; FlushD = PCSrcE.
REQ-024 When PCSrcE=1, stalls still assert; the flush takes precedence in the pipeline registers.
REQ-025 ForwardAE is evaluated per operand, in priority order:
  - 11 if MC_done & (MC_rd!=0) & (MC_rd==Rs1_E);
  - else 10 if RegWriteM & (RD_M!=0) & (RD_M==Rs1_E);
  - else 01 if RegWriteW & (RD_W!=0) & (RD_W==Rs1_E);
  - else 00.
REQ-026 ForwardBE is identical to REQ-025 using Rs2_E.
REQ-027 The multicycle result has highest priority because it is always the youngest writer; REQ-020 blocks any younger WAW.
REQ-028 A multicycle op with RD_E=0 still counts and pulses MC_done, but never forwards and never stalls on register match.
REQ-029 stall_cycles increments by 1 on each edge where StallD=1, saturates at all-ones, and never wraps.
REQ-030 All forward, stall and flush outputs are combinational; only the state in REQ-012 is registered.

Reset
REQ-031 rst=0 asynchronously clears mc_busy, mc_rd_q, cnt and stall_cycles to 0.
REQ-032 While rst=0, all outputs are forced to 0: ForwardAE=ForwardBE=00, StallF=StallD=FlushD=FlushE=0, MC_done=0, MC_rd=0.
REQ-033 Reset asserted mid-operation abandons the in-flight multicycle op; no MC_done is produced after rst is released.
REQ-034 Release of rst takes effect at the next rising clk edge; the first issue can be accepted in that cycle.

Verification
REQ-035 Forward priority: RegWriteM=1, RD_M=5, RegWriteW=1, RD_W=5, Rs1_E=5, Rs2_E=6, RD_W=6 variant -> ForwardAE=10; with RD_W=6, ForwardBE=01; with RD_M=0 and RD_W=0 -> both 00.
REQ-036 Load-use: MemReadE=1, RD_E=7, Rs2_D=7 -> StallF=StallD=FlushE=1 for one cycle; stall_cycles increments by 1.
REQ-037 Multicycle, MC_LAT=4: MC_issueE=1, RD_E=9 at cycle 0; Rs1_D=9 held -> StallD=1 in cycles 1-3; MC_done=1, MC_rd=9 in cycle 4 with StallD=0; Rs1_E=9 in cycle 4 -> ForwardAE=11, overriding RegWriteM=1, RD_M=9.
REQ-038 Back-to-back issue: second MC_issueE in the done cycle 4 -> accepted; next MC_done in cycle 8; a second MC_D held in D during busy -> StallD=1 in cycles 5-7.
REQ-039 Reset mid-op: rst=0 in cycle 2 of a busy op -> all outputs 0 immediately; after release, no MC_done and stall_cycles=0.
REQ-040 Saturation: STALL_CNT_W=4 with 20 stall cycles -> stall_cycles=15 and holds; PCSrcE=1 -> FlushD=FlushE=1 and StallD=0.
